panel_shifter: RTL
==================

PANEL_SHIFTER -- requirements
Module: panel_shifter

Interface
REQ-001 Parameter PWM_WIDTH, default 12, bits per colour channel and width of the PWM phase.
REQ-002 Parameter OE_GUARD, default 1, blanking cycles before and after each latch pulse.
REQ-003 clk_in  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 line  input  3  current scanline from the scan timing generator.
REQ-006 col  input  6  current column from the scan timing generator.
REQ-007 lat  input  1  high when col==0; marks the start of a scanline.
REQ-008 pwm  input  PWM_WIDTH  current PWM phase.
REQ-009 frame_clk  input  1  high for one cycle when the whole scan counter is zero.
REQ-010 blank  input  1  forces the panel dark while high.
REQ-011 fb_addr  output  9  framebuffer read address, {line,col}.
REQ-012 fb_data  input  6*PWM_WIDTH  pixel pair {r1,g1,b1,r0,g0,b0}, MSB first, valid exactly 1 cycle after fb_addr.
REQ-013 rgb  output  6  panel data {b1,g1,r1,b0,g0,r0}.
REQ-014 panel_clk  output  1  panel shift clock.
REQ-015 panel_lat  output  1  panel latch strobe.
REQ-016 panel_oe_n  output  1  panel output enable, active-low.
REQ-017 panel_abc  output  3  panel row select.
REQ-018 vsync  output  1  one-cycle pulse marking the frame boundary at the panel outputs.

Function
REQ-019 Stage 1 shall register fb_addr={line,col} and delay lat, line, pwm and frame_clk by one cycle.
REQ-020 Stage 2 shall compare each fb_data channel against the stage-1 pwm: bit = (channel > pwm), unsigned, PWM_WIDTH bits.
REQ-021 Stage 3 shall register the six compare bits onto rgb; total latency from col/line to rgb is 3 cycles.
REQ-022 panel_clk shall equal shift_en AND NOT clk_in, with shift_en registered; this is the block's only combinational output.
REQ-023 Consequence of REQ-022: panel_clk rises mid-cycle while rgb is stable.
REQ-024 shift_en shall be high in every cycle where rgb holds a valid stage-3 pixel; it is low for the first 3 cycles after reset.
REQ-025 panel_lat shall be high for exactly the one cycle in which the stage-3 copy of lat is high.
REQ-026 In that panel_lat cycle, panel_abc shall load the stage-3 line value held in the previous cycle (the line whose 64 bits were just shifted).
REQ-027 panel_lat shall be suppressed until at least 64 valid pixels have been shifted since reset; the first post-reset lat never latches.
REQ-028 panel_oe_n shall be 1 when blank is high, during reset, before the first permitted latch, and for OE_GUARD cycles before, during and after each panel_lat cycle.
REQ-029 panel_oe_n shall be 0 in all other cycles.
REQ-030 panel_oe_n shall be registered; blank takes effect 1 cycle after assertion.
REQ-031 vsync shall be frame_clk delayed 3 cycles.
REQ-032 PWM values: a channel of 0 is never lit; a channel of 2^PWM_WIDTH-1 is lit in all phases except the maximum.
REQ-033 col wrap 63->0 and line wrap 7->0 need no special handling beyond REQ-025/026.

Reset
REQ-034 On reset: rgb=0, shift_en=0 (panel_clk low), panel_lat=0, panel_oe_n=1, panel_abc=0, fb_addr=0, vsync=0, pipeline valid bits cleared, latch-permit flag cleared.
REQ-035 Reset asserted mid-line shall abort the shift immediately; no partial latch occurs after release until REQ-027 is satisfied again.

Structure
REQ-036 The shared package shall hold PWM_WIDTH default, pipeline latency constant (3) and the fb_data channel field offsets.
REQ-037 One sub-module, pixel_pwm, shall perform the six-channel compare of REQ-020.

Verification
REQ-038 Release reset at col=0, drive all-zero fb_data -> panel_clk pulses start at cycle 3, first panel_lat at cycle 67 (not cycle 3), rgb=0 throughout.
REQ-039 Line 2 with r0=0x800, others 0, pwm=0x7FF then 0x800 -> rgb[0]=1 at pwm 0x7FF, rgb[0]=0 at pwm 0x800, other bits 0.
REQ-040 Scan line 5 to the 5->6 boundary -> panel_lat high for one cycle with panel_abc=5, panel_oe_n=1 for 3 cycles centred on it.
REQ-041 blank=1 for 10 cycles mid-line -> panel_oe_n=1 from the next cycle for 10 cycles; rgb/panel_clk unaffected.
REQ-042 reset pulse at col=30 -> outputs reach reset values asynchronously; next panel_lat 64 shifted pixels after release.
REQ-043 frame_clk pulse -> vsync exactly 3 cycles later, coincident with rgb of pixel {0,0}.

Source files
------------

// File: rtl/panel_shifter_pkg.sv
// Shared constants for the panel_shifter block.
//   PWM_WIDTH_DEF : default bits per colour channel / PWM phase width
//   PIPE_LAT      : cycles from {line,col} at the inputs to the pixel on rgb
//   LINE_PIXELS   : pixels shifted per scanline before a latch is meaningful
//   CH_*          : channel index inside fb_data (bit offset = index*PWM_WIDTH)
//   RGB_*         : bit position of each channel on the rgb output
package panel_shifter_pkg;

  localparam int PWM_WIDTH_DEF = 12;
  localparam int PIPE_LAT      = 3;
  localparam int LINE_PIXELS   = 64;

  // fb_data is {r1,g1,b1,r0,g0,b0}, MSB first.
  localparam int CH_B0 = 0;
  localparam int CH_G0 = 1;
  localparam int CH_R0 = 2;
  localparam int CH_B1 = 3;
  localparam int CH_G1 = 4;
  localparam int CH_R1 = 5;

  // rgb is {b1,g1,r1,b0,g0,r0}.
  localparam int RGB_R0 = 0;
  localparam int RGB_G0 = 1;
  localparam int RGB_B0 = 2;
  localparam int RGB_R1 = 3;
  localparam int RGB_G1 = 4;
  localparam int RGB_B1 = 5;

endpackage

// File: rtl/panel_shifter_pixel_pwm.sv
// pixel_pwm: six-channel PWM comparator for one upper/lower pixel pair.
//   fb_data : {r1,g1,b1,r0,g0,b0}, PWM_WIDTH bits each
//   pwm     : current PWM phase, aligned with fb_data
//   lit     : per-channel (channel > pwm), arranged as {b1,g1,r1,b0,g0,r0}
module pixel_pwm
  import panel_shifter_pkg::*;
#(
  parameter int PWM_WIDTH = PWM_WIDTH_DEF
) (
  input  logic [6*PWM_WIDTH-1:0] fb_data,
  input  logic [PWM_WIDTH-1:0]   pwm,
  output logic [5:0]             lit
);

  logic [PWM_WIDTH-1:0] r0, g0, b0, r1, g1, b1;

  assign b0 = fb_data[CH_B0*PWM_WIDTH +: PWM_WIDTH];
  assign g0 = fb_data[CH_G0*PWM_WIDTH +: PWM_WIDTH];
  assign r0 = fb_data[CH_R0*PWM_WIDTH +: PWM_WIDTH];
  assign b1 = fb_data[CH_B1*PWM_WIDTH +: PWM_WIDTH];
  assign g1 = fb_data[CH_G1*PWM_WIDTH +: PWM_WIDTH];
  assign r1 = fb_data[CH_R1*PWM_WIDTH +: PWM_WIDTH];

  // Unsigned strict compare: a zero channel never lights, a full-scale
  // channel lights in every phase except the last.
  always_comb begin
    lit         = '0;
    lit[RGB_R0] = (r0 > pwm);
    lit[RGB_G0] = (g0 > pwm);
    lit[RGB_B0] = (b0 > pwm);
    lit[RGB_R1] = (r1 > pwm);
    lit[RGB_G1] = (g1 > pwm);
    lit[RGB_B1] = (b1 > pwm);
  end

endmodule

// File: rtl/panel_shifter.sv
// panel_shifter: turns framebuffer pixels into HUB75-style panel signals.
//   clk_in, reset      : clock, asynchronous active-high reset
//   line, col, lat     : scan position from the timing generator (lat at col 0)
//   pwm, frame_clk     : PWM phase and start-of-frame pulse
//   blank              : forces the panel dark (one cycle later)
//   fb_addr / fb_data  : framebuffer read port, data one cycle after address
//   rgb, panel_clk     : shift data and shift clock (panel_clk = shift_en & ~clk_in)
//   panel_lat, panel_abc, panel_oe_n : latch strobe, row select, output enable
//   vsync              : frame_clk aligned with the panel outputs
// OE_GUARD is supported in the range 0..2 (the latch lookahead is 3 cycles deep).
module panel_shifter
  import panel_shifter_pkg::*;
#(
  parameter int PWM_WIDTH = PWM_WIDTH_DEF,
  parameter int OE_GUARD  = 1
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic [2:0]             line,
  input  logic [5:0]             col,
  input  logic                   lat,
  input  logic [PWM_WIDTH-1:0]   pwm,
  input  logic                   frame_clk,
  input  logic                   blank,
  output logic [8:0]             fb_addr,
  input  logic [6*PWM_WIDTH-1:0] fb_data,
  output logic [5:0]             rgb,
  output logic                   panel_clk,
  output logic                   panel_lat,
  output logic                   panel_oe_n,
  output logic [2:0]             panel_abc,
  output logic                   vsync
);

  localparam logic [6:0] CNT_FULL    = 7'(LINE_PIXELS);
  localparam logic [2:0] AHEAD_MASK  = (OE_GUARD >= 2) ? 3'b111 :
                                       (OE_GUARD == 1) ? 3'b011 : 3'b001;
  localparam logic [1:0] POST_LOAD   = (OE_GUARD >= 2) ? 2'd2 : 2'(OE_GUARD);

  logic [8:0]           fb_addr_q,   fb_addr_d;
  logic                 vld_p1_q,    vld_p1_d;
  logic                 lat_p1_q,    lat_p1_d;
  logic [2:0]           line_p1_q,   line_p1_d;
  logic [PWM_WIDTH-1:0] pwm_p1_q,    pwm_p1_d;
  logic                 vld_p2_q,    vld_p2_d;
  logic                 lat_p2_q,    lat_p2_d;
  logic [2:0]           line_p2_q,   line_p2_d;
  logic [PWM_WIDTH-1:0] pwm_p2_q,    pwm_p2_d;
  logic [5:0]           rgb_q,       rgb_d;
  logic                 shift_en_q,  shift_en_d;
  logic [2:0]           line_p3_q,   line_p3_d;
  logic [PIPE_LAT-1:0]  frame_dly_q, frame_dly_d;
  logic [6:0]           shift_cnt_q, shift_cnt_d;
  logic                 panel_lat_q, panel_lat_d;
  logic [2:0]           panel_abc_q, panel_abc_d;
  logic                 latched_q,   latched_d;
  logic [1:0]           post_cnt_q,  post_cnt_d;
  logic                 oe_n_q,      oe_n_d;

  logic [5:0]           lit;
  logic [2:0]           lat_ahead;

  pixel_pwm #(.PWM_WIDTH(PWM_WIDTH)) u_pixel_pwm (
    .fb_data (fb_data),
    .pwm     (pwm_p2_q),
    .lit     (lit)
  );

  always_comb begin
    // stage 1: issue the framebuffer read, carry scan state alongside it
    fb_addr_d   = {line, col};
    vld_p1_d    = 1'b1;
    lat_p1_d    = lat;
    line_p1_d   = line;
    pwm_p1_d    = pwm;

    // stage 2: read data returns; pwm travels with its address so the
    // compare sees the phase that belongs to this pixel
    vld_p2_d    = vld_p1_q;
    lat_p2_d    = lat_p1_q;
    line_p2_d   = line_p1_q;
    pwm_p2_d    = pwm_p1_q;

    // stage 3: compare result onto the panel data pins
    rgb_d       = vld_p2_q ? lit : '0;
    shift_en_d  = vld_p2_q;
    line_p3_d   = line_p2_q;
    frame_dly_d = {frame_dly_q[PIPE_LAT-2:0], frame_clk};

    // Count shifted pixels since reset; a latch is only allowed once a
    // whole line has been clocked in, so the first partial line is dropped.
    shift_cnt_d = shift_cnt_q;
    if (shift_en_q && (shift_cnt_q != CNT_FULL)) begin
      shift_cnt_d = shift_cnt_q + 7'd1;
    end

    panel_lat_d = lat_p2_q & vld_p2_q & (shift_cnt_d == CNT_FULL);
    // Row select follows the line that was just shifted, i.e. the one held
    // in stage 3 before the new line's first pixel arrives.
    panel_abc_d = panel_lat_d ? line_p3_q : panel_abc_q;
    latched_d   = latched_q | panel_lat_d;

    post_cnt_d  = '0;
    if (panel_lat_q) begin
      post_cnt_d = POST_LOAD;
    end else if (post_cnt_q != 2'd0) begin
      post_cnt_d = post_cnt_q - 2'd1;
    end

    // Once the first latch has happened every lat becomes a latch, so the
    // raw and partly delayed lat copies predict upcoming latch cycles:
    // bit 0 -> next cycle, bit 1 -> two cycles on, bit 2 -> three on.
    lat_ahead   = {lat, lat_p1_q, lat_p2_q};
    oe_n_d      = blank | ~latched_d | (|(lat_ahead & AHEAD_MASK)) |
                  (post_cnt_d != 2'd0);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      fb_addr_q   <= '0;
      vld_p1_q    <= 1'b0;
      lat_p1_q    <= 1'b0;
      line_p1_q   <= '0;
      pwm_p1_q    <= '0;
      vld_p2_q    <= 1'b0;
      lat_p2_q    <= 1'b0;
      line_p2_q   <= '0;
      pwm_p2_q    <= '0;
      rgb_q       <= '0;
      shift_en_q  <= 1'b0;
      line_p3_q   <= '0;
      frame_dly_q <= '0;
      shift_cnt_q <= '0;
      panel_lat_q <= 1'b0;
      panel_abc_q <= '0;
      latched_q   <= 1'b0;
      post_cnt_q  <= '0;
      oe_n_q      <= 1'b1;
    end else begin
      fb_addr_q   <= fb_addr_d;
      vld_p1_q    <= vld_p1_d;
      lat_p1_q    <= lat_p1_d;
      line_p1_q   <= line_p1_d;
      pwm_p1_q    <= pwm_p1_d;
      vld_p2_q    <= vld_p2_d;
      lat_p2_q    <= lat_p2_d;
      line_p2_q   <= line_p2_d;
      pwm_p2_q    <= pwm_p2_d;
      rgb_q       <= rgb_d;
      shift_en_q  <= shift_en_d;
      line_p3_q   <= line_p3_d;
      frame_dly_q <= frame_dly_d;
      shift_cnt_q <= shift_cnt_d;
      panel_lat_q <= panel_lat_d;
      panel_abc_q <= panel_abc_d;
      latched_q   <= latched_d;
      post_cnt_q  <= post_cnt_d;
      oe_n_q      <= oe_n_d;
    end
  end

  assign fb_addr    = fb_addr_q;
  assign rgb        = rgb_q;
  // Shift clock rises in the middle of the cycle, while rgb is stable.
  assign panel_clk  = shift_en_q & ~clk_in;
  assign panel_lat  = panel_lat_q;
  assign panel_abc  = panel_abc_q;
  assign panel_oe_n = oe_n_q;
  assign vsync      = frame_dly_q[PIPE_LAT-1];

endmodule
